// File: rtl/neuron_bwd_pkg.sv
// Shared types and helpers for the backward linear neuron.
package neuron_bwd_pkg;

    // Upper bounds for the width-generic helpers below.
    localparam int unsigned MAX_W    = 64;
    localparam int unsigned MAX_FLAT = 4096;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Clamp a full-precision signed product to a w-bit signed range; caller keeps the low w bits.
    function automatic logic signed [MAX_W-1:0] sat_narrow(
        input logic signed [2*MAX_W-1:0] p,
        input int unsigned               w
    );
        logic signed [2*MAX_W-1:0] hi;
        logic signed [2*MAX_W-1:0] lo;
        logic signed [MAX_W-1:0]   r;
        hi = ((2*MAX_W)'(1) << (w - 1)) - (2*MAX_W)'(1);
        lo = ~hi;
        if (p > hi) begin
            r = hi[MAX_W-1:0];
        end else if (p < lo) begin
            r = lo[MAX_W-1:0];
        end else begin
            r = p[MAX_W-1:0];
        end
        return r;
    endfunction

    // Weight i of an n-element packed vector; element 0 is the most significant chunk.
    function automatic logic [MAX_W-1:0] weight_at(
        input logic [MAX_FLAT-1:0] flat,
        input int unsigned         n,
        input int unsigned         w,
        input int unsigned         i
    );
        logic [MAX_FLAT-1:0] sh;
        sh = flat >> ((n - 1 - i) * w);
        return sh[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/neuron_backward_sat_mul.sv
// Signed WIDTH x WIDTH multiply saturated back to WIDTH bits.
module neuron_backward_sat_mul
    import neuron_bwd_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] y_c
);

    logic signed [2*WIDTH-1:0] prod;

    // Full-precision product, then clamp into the output range.
    always_comb begin
        prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
        y_c  = WIDTH'(sat_narrow((2*MAX_W)'(prod), WIDTH));
    end

endmodule

// File: rtl/neuron_backward.sv
// Backward pass of a constant-weight linear neuron: one delta in, N gradient beats out.
module neuron_backward
    import neuron_bwd_pkg::*;
#(
    parameter int unsigned         WIDTH        = 16,
    parameter int unsigned         N            = 4,
    parameter logic [N*WIDTH-1:0]  WEIGHTS_FLAT = '0,
    parameter int unsigned         IDX_W        = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    delta_valid,
    output logic                    delta_ready,
    input  logic signed [WIDTH-1:0] delta,
    input  logic signed [WIDTH-1:0] x_in [N-1:0],
    output logic signed [WIDTH-1:0] grad_b,
    output logic                    grad_valid,
    input  logic                    grad_ready,
    output logic signed [WIDTH-1:0] grad_x,
    output logic signed [WIDTH-1:0] grad_w,
    output logic [IDX_W-1:0]        grad_idx,
    output logic                    grad_last
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [WIDTH-1:0] delta_q, delta_d;
    logic signed [WIDTH-1:0] x_q [N-1:0];
    logic signed [WIDTH-1:0] x_d [N-1:0];
    logic signed [WIDTH-1:0] w_cur;
    logic signed [WIDTH-1:0] x_cur;
    logic                    capture;

    // State, beat index and captured operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            delta_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            delta_q <= delta_d;
            for (int i = 0; i < int'(N); i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    // Next-state logic; a delta may be taken in IDLE or on the final handshake of a stream.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        delta_d     = delta_q;
        x_d         = x_q;
        delta_ready = 1'b0;
        capture     = 1'b0;
        case (state_q)
            IDLE: begin
                delta_ready = 1'b1;
                if (delta_valid) begin
                    capture = 1'b1;
                end
            end
            STREAM: begin
                if (grad_ready) begin
                    if (idx_q == LAST_IDX) begin
                        delta_ready = 1'b1;
                        if (delta_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (capture) begin
            state_d = STREAM;
            idx_d   = '0;
            delta_d = delta;
            x_d     = x_in;
        end
    end

    // Operand selection for the current beat.
    always_comb begin
        w_cur = WIDTH'(weight_at(MAX_FLAT'(WEIGHTS_FLAT), N, WIDTH, 32'(idx_q)));
        x_cur = x_q[idx_q];
    end

    neuron_backward_sat_mul #(.WIDTH(WIDTH)) u_mul_x (
        .a   (delta_q),
        .b   (w_cur),
        .y_c (grad_x)
    );

    neuron_backward_sat_mul #(.WIDTH(WIDTH)) u_mul_w (
        .a   (delta_q),
        .b   (x_cur),
        .y_c (grad_w)
    );

    // Beat qualifiers derived from registered state.
    always_comb begin
        grad_valid = (state_q == STREAM);
        grad_idx   = idx_q;
        grad_last  = grad_valid && (idx_q == LAST_IDX);
        grad_b     = delta_q;
    end

endmodule

// File: tb/tb_neuron_backward.sv
// Bench for neuron_backward: queue-based beat model plus literal spot checks.
module tb_neuron_backward;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    typedef struct {
        longint gx;
        longint gw;
        longint gb;
    } beat_t;

    typedef struct {
        longint gx;
        longint gw;
        longint idx;
        int     cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    logic                    delta_valid, delta_ready, grad_valid, grad_ready, grad_last;
    logic signed [WIDTH-1:0] delta, grad_b, grad_x, grad_w;
    logic signed [WIDTH-1:0] x_in [N-1:0];
    logic [1:0]              grad_idx;

    logic                    d1_valid, d1_ready, g1_valid, g1_ready, g1_last;
    logic signed [WIDTH-1:0] d1_delta, g1_b, g1_x, g1_w;
    logic signed [WIDTH-1:0] x1 [0:0];
    logic [0:0]              g1_idx;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    longint w4 [N] = '{3, -2, 32767, -32768};
    longint w1 [1] = '{5};

    beat_t q4[$];
    beat_t q1[$];
    obs_t  log4[$];
    obs_t  log1[$];

    neuron_backward #(
        .WIDTH(WIDTH), .N(N),
        .WEIGHTS_FLAT({16'sd3, -16'sd2, 16'sd32767, 16'h8000})
    ) dut (
        .clk(clk), .rst(rst),
        .delta_valid(delta_valid), .delta_ready(delta_ready),
        .delta(delta), .x_in(x_in),
        .grad_b(grad_b), .grad_valid(grad_valid), .grad_ready(grad_ready),
        .grad_x(grad_x), .grad_w(grad_w), .grad_idx(grad_idx), .grad_last(grad_last)
    );

    neuron_backward #(
        .WIDTH(WIDTH), .N(1), .WEIGHTS_FLAT(16'sd5)
    ) dut1 (
        .clk(clk), .rst(rst),
        .delta_valid(d1_valid), .delta_ready(d1_ready),
        .delta(d1_delta), .x_in(x1),
        .grad_b(g1_b), .grad_valid(g1_valid), .grad_ready(g1_ready),
        .grad_x(g1_x), .grad_w(g1_w), .grad_idx(g1_idx), .grad_last(g1_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic longint sat(input longint p);
        if (p > 32767)  return 32767;
        if (p < -32768) return -32768;
        return p;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Model for the N=4 instance: one queue entry per outstanding beat, front is the current one.
    always @(negedge clk) begin
        if (rst) begin
            q4.delete();
        end else begin
            bit exp_v, exp_rdy;
            exp_v   = (q4.size() != 0);
            exp_rdy = (q4.size() == 0) || (q4.size() == 1 && grad_ready);
            check("grad_valid", longint'(grad_valid), longint'(exp_v));
            check("delta_ready", longint'(delta_ready), longint'(exp_rdy));
            if (exp_v) begin
                check("grad_x", grad_x, q4[0].gx);
                check("grad_w", grad_w, q4[0].gw);
                check("grad_b", grad_b, q4[0].gb);
                check("grad_idx", longint'(grad_idx), longint'(N - q4.size()));
                check("grad_last", longint'(grad_last), longint'(q4.size() == 1));
                if (grad_ready) begin
                    log4.push_back('{gx: grad_x, gw: grad_w, idx: longint'(grad_idx), cyc: cyc});
                    void'(q4.pop_front());
                end
            end
            if (delta_valid && exp_rdy) begin
                for (int i = 0; i < N; i++) begin
                    q4.push_back('{gx: sat(longint'(delta) * w4[i]),
                                   gw: sat(longint'(delta) * longint'(x_in[i])),
                                   gb: longint'(delta)});
                end
            end
        end
    end

    // Model for the N=1 instance.
    always @(negedge clk) begin
        if (rst) begin
            q1.delete();
        end else begin
            bit exp_v, exp_rdy;
            exp_v   = (q1.size() != 0);
            exp_rdy = (q1.size() == 0) || g1_ready;
            check("n1_grad_valid", longint'(g1_valid), longint'(exp_v));
            check("n1_delta_ready", longint'(d1_ready), longint'(exp_rdy));
            if (exp_v) begin
                check("n1_grad_x", g1_x, q1[0].gx);
                check("n1_grad_w", g1_w, q1[0].gw);
                check("n1_grad_b", g1_b, q1[0].gb);
                check("n1_grad_idx", longint'(g1_idx), 0);
                check("n1_grad_last", longint'(g1_last), 1);
                if (g1_ready) begin
                    log1.push_back('{gx: g1_x, gw: g1_w, idx: longint'(g1_idx), cyc: cyc});
                    void'(q1.pop_front());
                end
            end
            if (d1_valid && exp_rdy) begin
                q1.push_back('{gx: sat(longint'(d1_delta) * w1[0]),
                               gw: sat(longint'(d1_delta) * longint'(x1[0])),
                               gb: longint'(d1_delta)});
            end
        end
    end

    function automatic longint log_gx(input int i);
        return (i < log4.size()) ? log4[i].gx : 999999;
    endfunction

    function automatic longint log_gw(input int i);
        return (i < log4.size()) ? log4[i].gw : 999999;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_x(input longint a, input longint b, input longint c, input longint d);
        x_in[0] = WIDTH'(a);
        x_in[1] = WIDTH'(b);
        x_in[2] = WIDTH'(c);
        x_in[3] = WIDTH'(d);
    endtask

    task automatic send4(input longint d);
        delta       = WIDTH'(d);
        delta_valid = 1'b1;
        tick(1);
        delta_valid = 1'b0;
        delta       = 16'sh1234;
    endtask

    initial begin
        longint exp_gx [N];
        longint exp_gw [N];

        rst = 1'b1;
        delta_valid = 1'b0; delta = '0; grad_ready = 1'b1;
        d1_valid = 1'b0; d1_delta = '0; g1_ready = 1'b1; x1[0] = '0;
        set_x(0, 0, 0, 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // Reset state.
        check("rst_grad_valid", longint'(grad_valid), 0);
        check("rst_delta_ready", longint'(delta_ready), 1);
        check("rst_grad_b", grad_b, 0);
        check("rst_grad_x", grad_x, 0);
        check("rst_grad_w", grad_w, 0);

        // Basic stream with saturating weights.
        log4.delete();
        set_x(1, 2, 3, 4);
        send4(2);
        check("lat_valid", longint'(grad_valid), 1);
        set_x(-9, -9, -9, -9);
        tick(6);
        exp_gx = '{6, -4, 32767, -32768};
        exp_gw = '{2, 4, 6, 8};
        check("basic_count", log4.size(), 4);
        for (int i = 0; i < N; i++) begin
            check("basic_gx", log_gx(i), exp_gx[i]);
            check("basic_gw", log_gw(i), exp_gw[i]);
        end

        // Stalls: ready pattern 1,0,0,1.
        log4.delete();
        set_x(1, 2, 3, 4);
        send4(2);
        for (int c = 0; c < 20; c++) begin
            grad_ready = (c % 4 == 0) || (c % 4 == 3);
            tick(1);
        end
        grad_ready = 1'b1;
        tick(2);
        check("stall_count", log4.size(), 4);
        for (int i = 0; i < N; i++) begin
            check("stall_gx", log_gx(i), exp_gx[i]);
        end

        // Back-to-back deltas with the second held until taken.
        log4.delete();
        set_x(1, 2, 3, 4);
        send4(2);
        delta = -16'sd1;
        delta_valid = 1'b1;
        tick(4);
        delta_valid = 1'b0;
        set_x(7, 7, 7, 7);
        tick(6);
        exp_gx = '{-3, 2, -32767, 32767};
        exp_gw = '{-1, -2, -3, -4};
        check("b2b_count", log4.size(), 8);
        check("b2b_gapless", (log4.size() == 8) ? longint'(log4[7].cyc - log4[0].cyc) : -1, 7);
        for (int i = 0; i < N; i++) begin
            check("b2b_gx", log_gx(i + 4), exp_gx[i]);
            check("b2b_gw", log_gw(i + 4), exp_gw[i]);
        end

        // Most negative delta against extreme inputs.
        log4.delete();
        set_x(-32768, 0, 1, -1);
        send4(-32768);
        tick(6);
        exp_gw = '{32767, 0, -32768, 32767};
        for (int i = 0; i < N; i++) begin
            check("minval_gw", log_gw(i), exp_gw[i]);
        end

        // Reset during a stalled beat 1.
        set_x(1, 2, 3, 4);
        send4(5);
        grad_ready = 1'b0;
        #1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", longint'(grad_valid), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        grad_ready = 1'b1;
        tick(3);
        check("post_rst_ready", longint'(delta_ready), 1);
        log4.delete();
        send4(2);
        tick(5);
        check("post_rst_idx0", (log4.size() > 0) ? log4[0].idx : -1, 0);
        check("post_rst_gx0", log_gx(0), 6);

        // Single-input neuron.
        log1.delete();
        d1_delta = 16'sd7;
        x1[0] = 16'sd3;
        d1_valid = 1'b1;
        tick(1);
        d1_valid = 1'b0;
        tick(3);
        check("n1_count", log1.size(), 1);
        check("n1_gx", (log1.size() > 0) ? log1[0].gx : -1, 35);
        check("n1_gw", (log1.size() > 0) ? log1[0].gw : -1, 21);

        // Randomized traffic on both instances.
        for (int c = 0; c < 600; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            delta = (sel == 0) ? -16'sd32768 : (sel == 1) ? 16'sd32767 : WIDTH'($urandom);
            for (int i = 0; i < N; i++) begin
                x_in[i] = ($urandom_range(0, 3) == 0) ? -16'sd32768 : WIDTH'($urandom);
            end
            delta_valid = ($urandom_range(0, 2) != 0);
            grad_ready  = ($urandom_range(0, 3) != 0);
            d1_delta    = WIDTH'($urandom);
            x1[0]       = WIDTH'($urandom);
            d1_valid    = $urandom_range(0, 1) == 1;
            g1_ready    = $urandom_range(0, 2) != 0;
            tick(1);
        end
        delta_valid = 1'b0;
        d1_valid    = 1'b0;
        grad_ready  = 1'b1;
        g1_ready    = 1'b1;
        tick(8);
        check("drain_valid", longint'(grad_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
